// File: rtl/ecb_decrypt_sequencer.sv
// ecb_decrypt_sequencer
// Feeds ciphertext blocks from a small FIFO into the ECB decryption core one at a
// time, captures each plaintext result and presents it on a valid/ready output.
// The core has no reset, so after rst the sequencer waits in DRAIN until the core
// reports idle and ignores any ready pulse that belongs to a block issued before rst.
module ecb_decrypt_sequencer #(
   parameter int DATA_WIDTH  = 128,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] key_in,
   input  logic                  key_load,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  dec_start,
   output logic [DATA_WIDTH-1:0] dec_ciphertext,
   output logic [DATA_WIDTH-1:0] dec_key,
   input  logic [DATA_WIDTH-1:0] dec_plaintext,
   input  logic                  dec_active,
   input  logic                  dec_ready,
   output logic                  busy,
   output logic [15:0]           blk_count,
   output logic                  err_timeout,
   output logic                  err_key_busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int WW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [2:0] {
      S_DRAIN,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full, empty, push, pop;

   logic                  dec_start_q;
   logic [DATA_WIDTH-1:0] dec_ct_q;
   logic [DATA_WIDTH-1:0] key_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_valid_q;
   logic [15:0]           blk_count_q;
   logic [WW-1:0]         wdog_q;
   logic                  err_timeout_q;
   logic                  err_key_busy_q;

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !rst && !full;
   // A push is only taken when not full, even if ISSUE frees an entry this cycle.
   assign push     = in_valid && in_ready;
   // ISSUE is only ever entered with a non-empty FIFO, so this pop never underflows.
   assign pop      = (state_q == S_ISSUE);

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // FIFO pointers and occupancy; reset flushes any queued blocks
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage, data only
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= in_data;
      end
   end

   // Sequencer FSM with key register, watchdog, output register and status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_DRAIN;
         dec_start_q    <= 1'b0;
         dec_ct_q       <= '0;
         key_q          <= '0;
         out_data_q     <= '0;
         out_valid_q    <= 1'b0;
         blk_count_q    <= '0;
         wdog_q         <= '0;
         err_timeout_q  <= 1'b0;
         err_key_busy_q <= 1'b0;
      end else begin
         // The key may only change while nothing is queued or in flight.
         if (key_load) begin
            if (state_q == S_IDLE && empty) begin
               key_q <= key_in;
            end else begin
               err_key_busy_q <= 1'b1;
            end
         end
         dec_start_q <= 1'b0;
         case (state_q)
            S_DRAIN: begin
               // Ready pulses seen here belong to a block issued before rst.
               if (!dec_active) begin
                  state_q <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (!empty && !out_valid_q) begin
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               dec_ct_q    <= fifo_mem_q[rd_ptr_q];
               dec_start_q <= 1'b1;
               wdog_q      <= '0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               wdog_q <= wdog_q + WW'(1);
               if (dec_ready) begin
                  out_data_q  <= dec_plaintext;
                  out_valid_q <= 1'b1;
                  state_q     <= S_OUT;
               end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                  // Give up on this block; the core may still be running, so drain.
                  err_timeout_q <= 1'b1;
                  state_q       <= S_DRAIN;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  blk_count_q <= blk_count_q + 16'd1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_DRAIN;
         endcase
      end
   end

   assign dec_start      = dec_start_q;
   assign dec_ciphertext = dec_ct_q;
   assign dec_key        = key_q;
   assign out_data       = out_data_q;
   assign out_valid      = out_valid_q;
   assign blk_count      = blk_count_q;
   assign err_timeout    = err_timeout_q;
   assign err_key_busy   = err_key_busy_q;
   assign busy           = (state_q != S_IDLE && state_q != S_DRAIN) || !empty || out_valid_q;

endmodule

// File: tb/tb_ecb_decrypt_sequencer.sv
// Testbench for ecb_decrypt_sequencer with a stub decryption core
// (ready 40 cycles after start, plaintext = ciphertext ^ key).
module tb_ecb_decrypt_sequencer;

   localparam int DW  = 128;
   localparam int TO  = 64;
   localparam int LAT = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] key_in;
   logic          key_load;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          dec_start;
   logic [DW-1:0] dec_ciphertext;
   logic [DW-1:0] dec_key;
   logic [DW-1:0] dec_plaintext;
   logic          dec_active;
   logic          dec_ready;
   logic          busy;
   logic [15:0]   blk_count;
   logic          err_timeout;
   logic          err_key_busy;

   ecb_decrypt_sequencer #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_in        (key_in),
      .key_load      (key_load),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .dec_start     (dec_start),
      .dec_ciphertext(dec_ciphertext),
      .dec_key       (dec_key),
      .dec_plaintext (dec_plaintext),
      .dec_active    (dec_active),
      .dec_ready     (dec_ready),
      .busy          (busy),
      .blk_count     (blk_count),
      .err_timeout   (err_timeout),
      .err_key_busy  (err_key_busy)
   );

   always #5 clk = ~clk;

   // Stub core: no reset, like the real one
   logic [6:0]    stub_cnt      = '0;
   logic          stub_active   = 1'b0;
   logic          stub_ready    = 1'b0;
   logic          stub_ready_en = 1'b1;
   logic [DW-1:0] stub_pt       = '0;

   always @(posedge clk) begin
      stub_ready <= 1'b0;
      if (dec_start) begin
         stub_cnt    <= 7'(LAT);
         stub_pt     <= dec_ciphertext ^ dec_key;
         stub_active <= 1'b1;
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 7'd1;
         if (stub_cnt == 7'd1) begin
            stub_active <= 1'b0;
            stub_ready  <= stub_ready_en;
         end
      end
   end

   assign dec_active    = stub_active;
   assign dec_ready     = stub_ready;
   assign dec_plaintext = stub_pt;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            checks = 0;
   int            passed = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] cur_key = '0;
   logic [DW-1:0] last_out = '0;
   int            n_starts = 0;
   int            last_start_cyc = 0;
   int            start_while_active = 0;

   // Monitor and scoreboard: sample on the falling edge
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (dec_start) begin
            n_starts++;
            last_start_cyc = cyc;
            if (stub_active) start_while_active++;
         end
         if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_output got=%h required=none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) $display("FAIL out_data got=%h required=%h", out_data, e);
               else passed++;
            end
            last_out = out_data;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running required=finished");
      $fatal(1, "simulation time limit");
   end

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_block(input logic [DW-1:0] ct, input bit track, output int waited);
      bit done;
      done   = 1'b0;
      waited = 0;
      in_data  = ct;
      in_valid = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            if (track) exp_q.push_back(ct ^ cur_key);
            done = 1'b1;
         end else begin
            waited++;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         $display("FAIL push_accept got=stalled required=accepted");
      end
   endtask

   task automatic wait_drain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      checks++;
      if (!done) $display("FAIL drain got=pending%0d required=0", exp_q.size());
      else passed++;
      tick(2);
   endtask

   task automatic wait_start(input int s0);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (n_starts > s0) done = 1'b1;
      end
      checks++;
      if (!done) $display("FAIL dec_start_seen got=0 required=1");
      else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1; key_in = '0; key_load = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      tick(3);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b required=0", out_valid); else passed++;
      checks++; if (dec_start !== 1'b0) $display("FAIL rst_dec_start got=%b required=0", dec_start); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b required=0", busy); else passed++;
      checks++; if (blk_count !== 16'd0) $display("FAIL rst_blk_count got=%0d required=0", blk_count); else passed++;
      checks++; if (err_timeout !== 1'b0 || err_key_busy !== 1'b0) $display("FAIL rst_errors got=%b%b required=00", err_timeout, err_key_busy); else passed++;
      checks++; if (dec_key !== '0) $display("FAIL rst_dec_key got=%h required=0", dec_key); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b required=0", in_ready); else passed++;
      checks++; if (out_data !== '0) $display("FAIL rst_out_data got=%h required=0", out_data); else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b required=1", in_ready); else passed++;
      tick(2);
   endtask

   task automatic test_single();
      int w;
      key_in = 128'h0F0E0D0C0B0A09080706050403020100;
      key_load = 1'b1;
      tick(1);
      key_load = 1'b0;
      cur_key = 128'h0F0E0D0C0B0A09080706050403020100;
      @(negedge clk);
      checks++; if (dec_key !== 128'h0F0E0D0C0B0A09080706050403020100) $display("FAIL key_load_idle got=%h required=0f0e..00", dec_key); else passed++;
      tick(1);
      out_ready = 1'b1;
      push_block({4{32'h11111111}}, 1'b1, w);
      wait_drain(200);
      checks++; if (last_out !== 128'h1E1F1C1D1A1B18191617141512131011) $display("FAIL single_plaintext got=%h required=1e1f1c1d1a1b18191617141512131011", last_out); else passed++;
      checks++; if (blk_count !== 16'd1) $display("FAIL single_blk_count got=%0d required=1", blk_count); else passed++;
      checks++; if (n_starts !== 1) $display("FAIL single_starts got=%0d required=1", n_starts); else passed++;
   endtask

   task automatic test_back_to_back();
      int w;
      int first_stall;
      first_stall = -1;
      for (int i = 0; i < 6; i++) begin
         push_block(rnd128(), 1'b1, w);
         if (w > 0 && first_stall < 0) first_stall = i;
      end
      checks++; if (first_stall !== 5) $display("FAIL b2b_first_stall got=%0d required=5", first_stall); else passed++;
      wait_drain(1000);
      checks++; if (blk_count !== 16'd7) $display("FAIL b2b_blk_count got=%0d required=7", blk_count); else passed++;
   endtask

   task automatic test_backpressure();
      int            w;
      int            s0;
      int            bad;
      bit            seen;
      logic [DW-1:0] held;
      out_ready = 1'b0;
      push_block(rnd128(), 1'b1, w);
      push_block(rnd128(), 1'b1, w);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL bp_out_valid got=0 required=1"); else passed++;
      s0   = n_starts;
      held = out_data;
      bad  = 0;
      repeat (200) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== held) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL bp_hold got=%0d_unstable_cycles required=0", bad); else passed++;
      checks++; if (n_starts !== s0) $display("FAIL bp_no_start got=%0d required=%0d", n_starts, s0); else passed++;
      tick(1);
      out_ready = 1'b1;
      wait_drain(300);
      checks++; if (blk_count !== 16'd9) $display("FAIL bp_blk_count got=%0d required=9", blk_count); else passed++;
   endtask

   task automatic test_key_busy();
      int            w;
      logic [DW-1:0] key2;
      key2 = rnd128();
      push_block(rnd128(), 1'b1, w);
      wait_start(n_starts);
      tick(1);
      key_in = key2;
      key_load = 1'b1;
      tick(1);
      key_load = 1'b0;
      @(negedge clk);
      checks++; if (dec_key !== cur_key) $display("FAIL key_busy_unchanged got=%h required=%h", dec_key, cur_key); else passed++;
      checks++; if (err_key_busy !== 1'b1) $display("FAIL err_key_busy got=%b required=1", err_key_busy); else passed++;
      wait_drain(200);
      key_in = key2;
      key_load = 1'b1;
      tick(1);
      key_load = 1'b0;
      cur_key = key2;
      @(negedge clk);
      checks++; if (dec_key !== key2) $display("FAIL key_load_after got=%h required=%h", dec_key, key2); else passed++;
      tick(1);
      push_block(rnd128(), 1'b1, w);
      wait_drain(200);
      checks++; if (blk_count !== 16'd11) $display("FAIL kb_blk_count got=%0d required=11", blk_count); else passed++;
   endtask

   task automatic test_timeout();
      int w;
      int err_cyc;
      bit seen;
      stub_ready_en = 1'b0;
      push_block(rnd128(), 1'b0, w);
      seen = 1'b0;
      err_cyc = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (err_timeout) begin
            seen = 1'b1;
            err_cyc = cyc;
         end
      end
      checks++; if (!seen) $display("FAIL err_timeout got=0 required=1"); else passed++;
      checks++; if (err_cyc - last_start_cyc !== TO) $display("FAIL timeout_cycles got=%0d required=%0d", err_cyc - last_start_cyc, TO); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL timeout_no_output got=%b required=0", out_valid); else passed++;
      tick(3);
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL timeout_idle got=busy required=idle"); else passed++;
      stub_ready_en = 1'b1;
      tick(1);
      push_block(rnd128(), 1'b1, w);
      wait_drain(200);
      checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky got=%b required=1", err_timeout); else passed++;
      checks++; if (blk_count !== 16'd12) $display("FAIL to_blk_count got=%0d required=12", blk_count); else passed++;
   endtask

   task automatic test_rst_mid();
      int w;
      int s0;
      bit idle;
      push_block(rnd128(), 1'b0, w);
      wait_start(n_starts);
      tick(20);
      push_block(rnd128(), 1'b0, w);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_q.delete();
      cur_key = '0;
      @(negedge clk);
      checks++; if (err_timeout !== 1'b0) $display("FAIL rst_mid_err_cleared got=%b required=0", err_timeout); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_mid_flushed got=busy required=idle"); else passed++;
      checks++; if (stub_active !== 1'b1) $display("FAIL rst_mid_core_active got=%b required=1", stub_active); else passed++;
      s0 = n_starts;
      tick(1);
      push_block(rnd128(), 1'b1, w);
      idle = 1'b0;
      for (int i = 0; i < 100 && !idle; i++) begin
         @(negedge clk);
         if (!stub_active) idle = 1'b1;
      end
      checks++; if (n_starts !== s0 || !idle) $display("FAIL drain_no_start got=%0d required=%0d", n_starts, s0); else passed++;
      wait_drain(200);
      checks++; if (blk_count !== 16'd1) $display("FAIL rst_mid_blk_count got=%0d required=1", blk_count); else passed++;
      checks++; if (start_while_active !== 0) $display("FAIL start_while_active got=%0d required=0", start_while_active); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_key_busy();
      test_timeout();
      test_rst_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
